// File: rtl/sdio_xfer_pkg.sv
// -----------------------------------------------------------------------------
// sdio_xfer_pkg
// Shared types and helpers for the sdio lane transfer engine.
//   xfer_state_e : engine sequencing states
//   RW_WRITE/RW_READ : encoding of the command direction bit
//   beats()      : number of lane beats needed to move one payload word
// -----------------------------------------------------------------------------
package sdio_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WR,
        TURN,
        RD,
        DONE
    } xfer_state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic int beats(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/sdio_lane_xfer_if.sv
// -----------------------------------------------------------------------------
// sdio_lane_xfer_if
// Command/response handshake plus split lane signals of the transfer engine.
// The lanes are presented as out/oe/in; the pad-level tristate that merges
// out and oe onto the shared wire sits outside the engine (oe=0 -> z).
//   cmd_valid/cmd_ready/cmd_rw/cmd_wdata : command request channel
//   rsp_valid/rsp_rdata                  : read response (no backpressure)
//   busy                                 : engine not idle
//   sdio_cs_n/sdio_out/sdio_oe/sdio_in   : serial bus side
// Modports: master = command issuer / remote lane driver, slave = engine.
// -----------------------------------------------------------------------------
interface sdio_lane_xfer_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              sdio_cs_n;
    logic [LANES-1:0]  sdio_out;
    logic [LANES-1:0]  sdio_oe;
    logic [LANES-1:0]  sdio_in;

    modport master (
        output cmd_valid, cmd_rw, cmd_wdata, sdio_in,
        input  cmd_ready, rsp_valid, rsp_rdata, busy,
               sdio_cs_n, sdio_out, sdio_oe
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_wdata, sdio_in,
        output cmd_ready, rsp_valid, rsp_rdata, busy,
               sdio_cs_n, sdio_out, sdio_oe
    );
endinterface

// File: rtl/sdio_lane_shifter.sv
// -----------------------------------------------------------------------------
// sdio_lane_shifter
// Payload shift register shared by the write and read directions.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_load        : capture i_load_data (command acceptance)
//   i_load_data   : parallel write payload
//   i_shift_out   : move the next write beat up to the top lanes
//   i_shift_in    : shift i_lanes_in in at the LSB side
//   i_lanes_in    : sampled lane values
//   o_top         : top LANES bits (the beat to drive next)
//   o_capture     : register value after one more shift-in of i_lanes_in
// Both directions shift toward the MSB, so write data leaves MSB-first and
// read data assembles with the first beat ending in the MSBs.
// -----------------------------------------------------------------------------
module sdio_lane_shifter #(
    parameter int LANES  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift_out,
    input  logic              i_shift_in,
    input  logic [LANES-1:0]  i_lanes_in,
    output logic [LANES-1:0]  o_top,
    output logic [DATA_W-1:0] o_capture
);
    logic [DATA_W-1:0]       r_sreg;
    logic [DATA_W+LANES-1:0] w_cat;

    // Concatenation keeps the shift-in legal even when DATA_W == LANES.
    assign w_cat     = {r_sreg, i_lanes_in};
    assign o_capture = w_cat[DATA_W-1:0];
    assign o_top     = r_sreg[DATA_W-1 -: LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
        end else if (i_load) begin
            // NOTE: non-blocking (<=) for every flop so all registers update
            // from pre-edge values regardless of block evaluation order.
            r_sreg <= i_load_data;
        end else if (i_shift_in) begin
            r_sreg <= o_capture;
        end else if (i_shift_out) begin
            r_sreg <= r_sreg << LANES;
        end
    end
endmodule

// File: rtl/sdio_lane_xfer.sv
// -----------------------------------------------------------------------------
// sdio_lane_xfer
// Half-duplex serial transfer engine: one parallel command becomes a framed
// transaction over LANES data lines.
//   Frame (cs_n low): HDR, then BEATS write beats, or TURN_CYC turnaround
//   cycles followed by BEATS read beats. A read ends with a one-cycle DONE
//   carrying the rsp_valid pulse.
// Parameters: LANES (1/2/4/8), DATA_W (multiple of LANES), TURN_CYC (>= 0).
// Ports:
//   sclk  : bus clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any frame, lanes release
//   bus   : sdio_lane_xfer_if.slave (command, response, busy, lane signals)
// -----------------------------------------------------------------------------
module sdio_lane_xfer
    import sdio_xfer_pkg::*;
#(
    parameter int LANES    = 1,
    parameter int DATA_W   = 16,
    parameter int TURN_CYC = 2
) (
    input  logic             sclk,
    input  logic             rst_n,
    sdio_lane_xfer_if.slave  bus
);
    localparam int BEATS   = beats(DATA_W, LANES);
    localparam int CNT_MAX = (BEATS > TURN_CYC) ? ((BEATS > 2) ? BEATS : 2)
                                                : ((TURN_CYC > 2) ? TURN_CYC : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_TURN = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

    xfer_state_e       r_state;
    xfer_state_e       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw;
    logic              r_cs_n;
    logic [LANES-1:0]  r_oe;
    logic [LANES-1:0]  r_out;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_cs_n_next;
    logic [LANES-1:0]  w_oe_next;
    logic [LANES-1:0]  w_out_next;
    logic              w_shift_out;
    logic              w_shift_in;
    logic              w_last_rd;
    logic [LANES-1:0]  w_top;
    logic [DATA_W-1:0] w_capture;

    assign w_accept   = bus.cmd_valid && (r_state == IDLE);
    assign w_shift_in = (r_state == RD);
    assign w_last_rd  = (r_state == RD) && (r_cnt == LAST_BEAT);

    sdio_lane_shifter #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk         (sclk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_data (bus.cmd_wdata),
        .i_shift_out (w_shift_out),
        .i_shift_in  (w_shift_in),
        .i_lanes_in  (bus.sdio_in),
        .o_top       (w_top),
        .o_capture   (w_capture)
    );

    // Next state, plus the lane/select values for the state being entered:
    // outputs are registered, so they are computed from w_state_next.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_state_next = r_state;
        w_cs_n_next  = 1'b1;
        w_oe_next    = '0;
        w_out_next   = '0;
        w_shift_out  = 1'b0;

        unique case (r_state)
            IDLE: if (w_accept) w_state_next = HDR;
            HDR: begin
                if (r_rw == RW_READ) w_state_next = (TURN_CYC > 0) ? TURN : RD;
                else                 w_state_next = WR;
            end
            WR:   if (r_cnt == LAST_BEAT) w_state_next = IDLE;
            TURN: if (r_cnt == LAST_TURN) w_state_next = RD;
            RD:   if (r_cnt == LAST_BEAT) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        unique case (w_state_next)
            HDR: begin
                // HDR is only entered on acceptance, so the live cmd_rw is
                // the value being latched into r_rw at the same edge.
                w_cs_n_next           = 1'b0;
                w_oe_next             = '1;
                w_out_next[LANES-1]   = bus.cmd_rw;
            end
            WR: begin
                // Drive the current top beat and advance the shifter together.
                w_cs_n_next = 1'b0;
                w_oe_next   = '1;
                w_out_next  = w_top;
                w_shift_out = 1'b1;
            end
            TURN, RD: w_cs_n_next = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw <= RW_WRITE;
        end else if (w_accept) begin
            r_rw <= bus.cmd_rw;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n      <= 1'b1;
            r_oe        <= '0;
            r_out       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cs_n      <= w_cs_n_next;
            r_oe        <= w_oe_next;
            r_out       <= w_out_next;
            r_rsp_valid <= (w_state_next == DONE);
        end
    end

    // The final read beat is folded in directly so rsp_rdata is ready in DONE;
    // it then holds until the next read completes.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_rdata <= '0;
        end else if (w_last_rd) begin
            r_rsp_rdata <= w_capture;
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sdio_cs_n = r_cs_n;
    assign bus.sdio_oe   = r_oe;
    assign bus.sdio_out  = r_out;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_sdio_lane_xfer.sv
// -----------------------------------------------------------------------------
// tb_sdio_lane_xfer
// Two engines share one clock and reset:
//   dut_a : LANES=4, DATA_W=16, TURN_CYC=2
//   dut_b : LANES=1, DATA_W=8,  TURN_CYC=0
// Each transaction is checked as a whole frame against the expected framing:
// header bit, frame length, drive-enable pattern, write beats reassembled
// into a word, and the read word rebuilt from the beats the bench drove.
// -----------------------------------------------------------------------------
module tb_sdio_lane_xfer;
    import sdio_xfer_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;
    int hi_run_a = 0;
    int last_gap_a = 0;
    int contention = 0;

    sdio_lane_xfer_if #(.LANES(4), .DATA_W(16)) a_if ();
    sdio_lane_xfer_if #(.LANES(1), .DATA_W(8))  b_if ();

    sdio_lane_xfer #(.LANES(4), .DATA_W(16), .TURN_CYC(2)) dut_a (
        .sclk  (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    sdio_lane_xfer #(.LANES(1), .DATA_W(8), .TURN_CYC(0)) dut_b (
        .sclk  (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive-enable must never be active outside the driven part of a frame.
    always @(negedge clk) begin
        if (a_if.sdio_oe != '0 &&
            (a_if.sdio_cs_n || (dut_a.r_state inside {TURN, RD, DONE})))
            contention++;
        if (b_if.sdio_oe != '0 &&
            (b_if.sdio_cs_n || (dut_b.r_state inside {TURN, RD, DONE})))
            contention++;
    end

    // All sampling and driving happens just after a falling edge.
    task automatic tick();
        @(negedge clk);
        if (a_if.sdio_cs_n) begin
            hi_run_a++;
        end else begin
            if (hi_run_a != 0) last_gap_a = hi_run_a;
            hi_run_a = 0;
        end
    endtask

    function automatic logic f_cs(input bit sel);
        return sel ? b_if.sdio_cs_n : a_if.sdio_cs_n;
    endfunction
    function automatic logic [3:0] f_oe(input bit sel);
        return sel ? {3'b000, b_if.sdio_oe} : a_if.sdio_oe;
    endfunction
    function automatic logic [3:0] f_out(input bit sel);
        return sel ? {3'b000, b_if.sdio_out} : a_if.sdio_out;
    endfunction
    function automatic logic f_ready(input bit sel);
        return sel ? b_if.cmd_ready : a_if.cmd_ready;
    endfunction
    function automatic logic f_busy(input bit sel);
        return sel ? b_if.busy : a_if.busy;
    endfunction
    function automatic logic f_rv(input bit sel);
        return sel ? b_if.rsp_valid : a_if.rsp_valid;
    endfunction
    function automatic logic [15:0] f_rd(input bit sel);
        return sel ? {8'h00, b_if.rsp_rdata} : a_if.rsp_rdata;
    endfunction

    task automatic drive_cmd(input bit sel, input logic v, input logic rw, input logic [15:0] wd);
        if (sel) begin
            b_if.cmd_valid = v;
            b_if.cmd_rw    = rw;
            b_if.cmd_wdata = wd[7:0];
        end else begin
            a_if.cmd_valid = v;
            a_if.cmd_rw    = rw;
            a_if.cmd_wdata = wd;
        end
    endtask

    task automatic drive_in(input bit sel, input logic [3:0] v);
        if (sel) b_if.sdio_in = v[0];
        else     a_if.sdio_in = v;
    endtask

    // One complete transaction. rd_word is what the remote side returns,
    // sent MSB-first, LANES bits per beat. With hold set, cmd_valid stays
    // high after acceptance carrying the next command (nrw/nwd).
    task automatic xfer(input bit sel, input bit rw, input logic [15:0] wd,
                        input logic [15:0] rd_word, input bit hold,
                        input bit nrw, input logic [15:0] nwd);
        int          lanes, nbeats, turn, dw, all1, n, len, sh;
        logic [31:0] oe_mask;
        logic [31:0] exp_mask;
        bit          oe_bad;
        logic [15:0] wr_word;
        logic [15:0] msk;
        logic [3:0]  out_rest;
        logic [3:0]  hdr_out;
        logic [3:0]  hdr_exp;
        logic [3:0]  o;
        logic [3:0]  e;
        string       id;

        lanes  = sel ? 1 : 4;
        nbeats = sel ? 8 : 4;
        turn   = sel ? 0 : 2;
        dw     = sel ? 8 : 16;
        all1   = (1 << lanes) - 1;
        msk    = (dw == 16) ? 16'hFFFF : 16'h00FF;
        id     = $sformatf("%s_%s", sel ? "b" : "a", rw ? "rd" : "wr");

        drive_cmd(sel, 1'b1, rw, wd);
        n = 0;
        while (!f_ready(sel) && n < 50) begin
            tick();
            n++;
        end
        if (!f_ready(sel)) begin
            check({id, "_accept_timeout"}, 32'd0, 32'd1);
            drive_cmd(sel, 1'b0, 1'b0, 16'h0);
            return;
        end
        tick();
        check({id, "_busy_ready_in_hdr"}, {f_busy(sel), f_ready(sel)}, 2'b10);

        if (hold) drive_cmd(sel, 1'b1, nrw, nwd);
        else      drive_cmd(sel, 1'b0, ~rw, ~wd);

        len      = 0;
        oe_mask  = '0;
        oe_bad   = 1'b0;
        wr_word  = '0;
        out_rest = '0;
        hdr_out  = f_out(sel);
        while (!f_cs(sel) && len < 40) begin
            o = f_out(sel);
            e = f_oe(sel);
            if (len < 32) oe_mask[len] = (e == all1[3:0]);
            if (e != 4'h0 && e != all1[3:0]) oe_bad = 1'b1;
            if (!rw && len >= 1 && len <= nbeats) wr_word = (wr_word << lanes) | {12'h000, o};
            if (rw && len >= 1) out_rest = out_rest | o;
            if (rw && len >= 1 + turn && len < 1 + turn + nbeats) begin
                sh = dw - lanes * (len - turn);
                drive_in(sel, 4'((rd_word >> sh) & all1));
            end else begin
                drive_in(sel, 4'($urandom));
            end
            tick();
            len++;
        end

        hdr_exp  = rw ? 4'(1 << (lanes - 1)) : 4'h0;
        exp_mask = rw ? 32'd1 : ((32'd1 << (1 + nbeats)) - 32'd1);
        check({id, "_hdr_out"}, hdr_out, hdr_exp);
        check({id, "_frame_len"}, len, rw ? (1 + turn + nbeats) : (1 + nbeats));
        check({id, "_oe_pattern"}, oe_mask, exp_mask);
        check({id, "_oe_partial"}, oe_bad, 1'b0);
        if (!rw) begin
            check({id, "_serial_data"}, wr_word, wd & msk);
            check({id, "_end_rv_busy"}, {f_rv(sel), f_busy(sel)}, 2'b00);
        end else begin
            check({id, "_out_idle_lanes"}, out_rest, 4'h0);
            check({id, "_rsp_valid"}, f_rv(sel), 1'b1);
            check({id, "_rsp_rdata"}, f_rd(sel), rd_word & msk);
            tick();
            check({id, "_rsp_pulse_end"}, f_rv(sel), 1'b0);
            check({id, "_rdata_hold"}, f_rd(sel), rd_word & msk);
        end
    endtask

    initial begin
        bit          sel;
        bit          rw;
        logic [15:0] wd;
        logic [15:0] rd;
        int          n;

        rst_n = 1'b0;
        drive_cmd(1'b0, 1'b0, 1'b0, 16'h0);
        drive_cmd(1'b1, 1'b0, 1'b0, 16'h0);
        drive_in(1'b0, 4'h0);
        drive_in(1'b1, 4'h0);
        repeat (3) tick();

        // Reset state: {cs_n, oe, out, rsp_valid, busy, ready}
        check("rst_a_outputs",
              {a_if.sdio_cs_n, a_if.sdio_oe, a_if.sdio_out, a_if.rsp_valid, a_if.busy, a_if.cmd_ready},
              {1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1});
        check("rst_a_rdata", a_if.rsp_rdata, 16'h0);
        check("rst_b_outputs",
              {b_if.sdio_cs_n, b_if.sdio_oe, b_if.sdio_out, b_if.rsp_valid, b_if.busy, b_if.cmd_ready},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;
        tick();

        // Directed frames
        xfer(1'b0, 1'b0, 16'hA5C3, 16'h0000, 1'b0, 1'b0, 16'h0);
        tick();
        xfer(1'b0, 1'b1, 16'h0000, 16'h3C5A, 1'b0, 1'b0, 16'h0);
        xfer(1'b1, 1'b1, 16'h0000, 16'h00B2, 1'b0, 1'b0, 16'h0);
        tick();

        // Back-to-back with cmd_valid held high: write, then read
        xfer(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b1, 16'h0F0F);
        xfer(1'b0, 1'b1, 16'h0F0F, 16'h9E61, 1'b0, 1'b0, 16'h0);
        check("b2b_cs_high_gap", last_gap_a, 1);
        tick();

        // Reset abort during the second read beat
        drive_cmd(1'b0, 1'b1, 1'b1, 16'h0);
        check("abort_ready", a_if.cmd_ready, 1'b1);
        tick();
        drive_cmd(1'b0, 1'b0, 1'b0, 16'h0);
        drive_in(1'b0, 4'h7);
        repeat (4) tick();
        check("abort_in_frame", {a_if.busy, a_if.sdio_cs_n}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_oe", a_if.sdio_oe, 4'h0);
        check("abort_cs_n", a_if.sdio_cs_n, 1'b1);
        check("abort_busy", a_if.busy, 1'b0);
        check("abort_rsp_valid", a_if.rsp_valid, 1'b0);
        repeat (3) begin
            tick();
            check("abort_no_rsp", a_if.rsp_valid, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        check("abort_no_rsp_after", a_if.rsp_valid, 1'b0);
        xfer(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0);
        tick();

        // Randomized transactions on both engines
        for (int t = 0; t < 40; t++) begin
            sel = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            wd  = 16'($urandom);
            rd  = 16'($urandom);
            xfer(sel, rw, wd, rd, 1'b0, 1'b0, 16'h0);
            n = $urandom_range(0, 2);
            repeat (n) tick();
        end

        check("no_oe_contention", contention, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
